// File: rtl/color_input_encoder.sv
// Four-button color entry: synchronizes and debounces one-hot presses, presents the
// encoded color until ack or timeout, then waits for a clean release before re-arming.
module color_input_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 50,
    parameter int IN_BITS         = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         btn,
    input  logic               ack,
    output logic [IN_BITS:0]   color,
    output logic               valid,
    output logic               dropped,
    output logic [7:0]         press_count
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    localparam logic [IN_BITS:0] C_RED    = (IN_BITS+1)'(0);
    localparam logic [IN_BITS:0] C_GREEN  = (IN_BITS+1)'(1);
    localparam logic [IN_BITS:0] C_BLUE   = (IN_BITS+1)'(2);
    localparam logic [IN_BITS:0] C_YELLOW = (IN_BITS+1)'(3);
    localparam logic [IN_BITS:0] C_NULL   = (IN_BITS+1)'(4);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        sync1_q, s_btn_q;
    logic [3:0]        cand_q, cand_d;
    logic [DW-1:0]     db_cnt_q, db_cnt_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [IN_BITS:0]  color_q, color_d;
    logic              valid_q, valid_d;
    logic              dropped_q, dropped_d;
    logic [7:0]        count_q, count_d;
    logic              s_onehot;

    function automatic logic [IN_BITS:0] encode(input logic [3:0] b);
        case (b)
            4'b0001: encode = C_RED;
            4'b0010: encode = C_GREEN;
            4'b0100: encode = C_BLUE;
            4'b1000: encode = C_YELLOW;
            default: encode = C_NULL;
        endcase
    endfunction

    assign s_onehot = (s_btn_q != 4'b0) && ((s_btn_q & (s_btn_q - 4'b1)) == 4'b0);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        color_d    = C_NULL;
        valid_d    = 1'b0;
        dropped_d  = 1'b0;
        count_d    = count_q;

        case (state_q)
            IDLE: begin
                if (s_onehot) begin
                    cand_d   = s_btn_q;
                    db_cnt_d = '0;
                    state_d  = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (s_btn_q != cand_q) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = PRESSED;
                    color_d    = encode(cand_q);
                    valid_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                // ack takes priority over a timeout in the same cycle
                if (ack) begin
                    count_d  = count_q + 8'd1;
                    db_cnt_d = '0;
                    state_d  = WAIT_RELEASE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    dropped_d = 1'b1;
                    db_cnt_d  = '0;
                    state_d   = WAIT_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    color_d    = color_q;
                    valid_d    = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (s_btn_q != 4'b0) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 4'b0;
            s_btn_q    <= 4'b0;
            state_q    <= IDLE;
            cand_q     <= 4'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            color_q    <= C_NULL;
            valid_q    <= 1'b0;
            dropped_q  <= 1'b0;
            count_q    <= 8'd0;
        end else begin
            sync1_q    <= btn;
            s_btn_q    <= sync1_q;
            state_q    <= state_d;
            cand_q     <= cand_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            color_q    <= color_d;
            valid_q    <= valid_d;
            dropped_q  <= dropped_d;
            count_q    <= count_d;
        end
    end

    assign color       = color_q;
    assign valid       = valid_q;
    assign dropped     = dropped_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_color_input_encoder.sv
// Self-checking bench: directed table, multi-cycle corner sequences, and random
// button traffic checked against a rule-level reference model.
module tb_color_input_encoder;

    localparam int D = 4;
    localparam int H = 10;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic       ack;
    logic [2:0] color;
    logic       valid;
    logic       dropped;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_errors = 0;

    color_input_encoder #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .IN_BITS(2)) dut (
        .clk(clk), .reset(reset), .btn(btn), .ack(ack),
        .color(color), .valid(valid), .dropped(dropped), .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the player has done, in terms of the rules.
    int m_s1, m_s;                 // button value 1 and 2 edges late
    int m_cand;                    // button being debounced, 0 = none
    int m_run, m_age, m_rel;
    bit m_present, m_waiting, m_drop;
    int m_code, m_count;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s = 0; m_cand = 0; m_run = 0; m_age = 0; m_rel = 0;
        m_present = 0; m_waiting = 0; m_drop = 0; m_code = 4; m_count = 0;
    endtask

    task automatic model_edge(input logic [3:0] b, input logic a);
        int s;
        s = m_s;
        m_drop = 0;
        if (m_present) begin
            if (a) begin
                m_count = (m_count + 1) % 256;
                m_present = 0; m_waiting = 1; m_rel = 0;
            end else if (m_age == H - 1) begin
                m_drop = 1; m_present = 0; m_waiting = 1; m_rel = 0;
            end else begin
                m_age++;
            end
        end else if (m_waiting) begin
            if (s != 0) m_rel = 0;
            else if (m_rel == D - 1) m_waiting = 0;
            else m_rel++;
        end else if (m_cand != 0) begin
            if (s != m_cand) m_cand = 0;
            else if (m_run == D - 1) begin
                for (int i = 0; i < 4; i++) if (m_cand == (1 << i)) m_code = i;
                m_present = 1; m_age = 0; m_cand = 0;
            end else m_run++;
        end else if ($countones(s) == 1) begin
            m_cand = s; m_run = 0;
        end
        m_s  = m_s1;
        m_s1 = int'(b);
    endtask

    function automatic int model_out();
        int c;
        c = m_present ? m_code : 4;
        return (int'(m_present) << 12) | (c << 9) | (int'(m_drop) << 8) | m_count;
    endfunction

    // One clock: drive inputs, advance the model on the edge, compare at the falling edge.
    task automatic step(input logic [3:0] b, input logic a);
        btn = b;
        ack = a;
        @(posedge clk);
        model_edge(b, a);
        @(negedge clk);
        check("model {valid,color,dropped,count}",
              int'({valid, color, dropped, press_count}), model_out());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn = 4'b0;
        ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset valid", int'(valid), 0);
        check("reset color", int'(color), 4);
        check("reset dropped", int'(dropped), 0);
        check("reset count", int'(press_count), 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_valid(input logic [3:0] b);
        int n;
        n = 0;
        while (!valid && n < 30) begin
            step(b, 1'b0);
            n++;
        end
        check("wait_valid within budget", int'(valid), 1);
    endtask

    task automatic release_idle();
        for (int i = 0; i < D + 4; i++) step(4'b0, 1'b0);
    endtask

    typedef struct {
        logic [3:0] btn;
        logic       ack;
        logic       exp_valid;
        logic [2:0] exp_color;
        logic       exp_drop;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int nv, ndrop, bad;
        logic [3:0] rb;
        int dur;

        tbl[0] = '{4'b0100, 1'b0, 1'b0, 3'd4, 1'b0, 8'd0};
        tbl[1] = '{4'b0100, 1'b0, 1'b0, 3'd4, 1'b0, 8'd0};
        tbl[2] = '{4'b0100, 1'b0, 1'b0, 3'd4, 1'b0, 8'd0};
        tbl[3] = '{4'b0100, 1'b0, 1'b0, 3'd4, 1'b0, 8'd0};
        tbl[4] = '{4'b0100, 1'b0, 1'b0, 3'd4, 1'b0, 8'd0};
        tbl[5] = '{4'b0100, 1'b0, 1'b0, 3'd4, 1'b0, 8'd0};
        tbl[6] = '{4'b0100, 1'b0, 1'b1, 3'd2, 1'b0, 8'd0};
        tbl[7] = '{4'b0100, 1'b1, 1'b0, 3'd4, 1'b0, 8'd1};
        tbl[8] = '{4'b0100, 1'b1, 1'b0, 3'd4, 1'b0, 8'd1};
        tbl[9] = '{4'b0000, 1'b0, 1'b0, 3'd4, 1'b0, 8'd1};

        do_reset();

        // Blue held, ack on the first valid cycle: valid at edge 7.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].btn, tbl[i].ack);
            check($sformatf("table[%0d]", i),
                  int'({valid, color, dropped, press_count}),
                  int'({tbl[i].exp_valid, tbl[i].exp_color, tbl[i].exp_drop, tbl[i].exp_cnt}));
        end
        release_idle();

        // Two-cycle glitch on red never becomes a press.
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step((i < 2) ? 4'b0001 : 4'b0000, 1'b0);
            if (valid || color != 3'd4) bad++;
        end
        check("glitch never valid", bad, 0);

        // Yellow held without ack: 10 valid cycles, one drop, no re-press while held.
        wait_valid(4'b1000);
        check("yellow color", int'(color), 3);
        nv = 1; ndrop = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b1000, 1'b0);
            if (dropped) ndrop++;
            if (valid) nv++;
            else break;
        end
        check("valid cycles before timeout", nv, H);
        check("dropped pulse seen", ndrop, 1);
        step(4'b1000, 1'b0);
        check("dropped is one cycle", int'(dropped), 0);
        check("count unchanged after drop", int'(press_count), 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(4'b1000, 1'b0);
            if (valid) bad++;
        end
        check("held button no re-press", bad, 0);
        release_idle();

        // Two buttons at once are ignored.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0011, 1'b0);
            if (valid || color != 3'd4) bad++;
        end
        check("multi-button ignored", bad, 0);
        release_idle();

        // Stray ack while idle does nothing.
        step(4'b0000, 1'b1);
        check("ack while idle ignored", int'(press_count), 1);

        // Asynchronous reset between edges while valid.
        wait_valid(4'b0010);
        #2 reset = 1'b1;
        #1;
        check("async reset valid", int'(valid), 0);
        check("async reset color", int'(color), 4);
        check("async reset count", int'(press_count), 0);
        btn = 4'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < D + 3; i++) step(4'b0001, 1'b0);
        check("restart latency valid", int'(valid), 1);
        check("restart color red", int'(color), 0);
        step(4'b0001, 1'b1);
        release_idle();

        // 256 acknowledged presses wrap the counter.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            wait_valid(4'b0001);
            step(4'b0001, 1'b1);
            release_idle();
        end
        check("count wraps to 0", int'(press_count), 0);

        // ack on the exact timeout cycle is counted, not dropped.
        wait_valid(4'b0100);
        for (int i = 0; i < H - 1; i++) step(4'b0100, 1'b0);
        check("still valid before timeout", int'(valid), 1);
        step(4'b0100, 1'b1);
        check("coincident ack counted", int'(press_count), 1);
        check("coincident ack no drop", int'(dropped), 0);
        check("coincident ack valid low", int'(valid), 0);
        release_idle();

        // Random button traffic against the model.
        for (int seg = 0; seg < 250; seg++) begin
            case ($urandom_range(7, 0))
                0: rb = 4'b0001;
                1: rb = 4'b0010;
                2: rb = 4'b0100;
                3: rb = 4'b1000;
                4, 5: rb = 4'b0000;
                6: rb = 4'($urandom_range(15, 0));
                default: rb = 4'b0101;
            endcase
            dur = $urandom_range(12, 1);
            for (int i = 0; i < dur; i++) step(rb, ($urandom_range(3, 0) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/color_input_encoder.md
COLOR_INPUT_ENCODER -- requirements
Module: color_input_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a press or a release.
REQ-002 SHALL have parameter HOLD_CYCLES, default 50: maximum cycles a presented color waits for ack.
REQ-003 SHALL have parameter IN_BITS, default 2; the color bus is IN_BITS+1 bits wide.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port btn, input, 4 bits: raw asynchronous buttons, active-high. Bit 0 is red, bit 1 green, bit 2 blue, bit 3 yellow.
REQ-007 SHALL have port ack, input, 1 bit: the consumer accepts the presented color.
REQ-008 SHALL have port color, output, IN_BITS+1 bits: the encoded player color. RED=0, GREEN=1, BLUE=2, YELLOW=3, NULL=4.
REQ-009 SHALL have port valid, output, 1 bit: color holds an accepted press.
REQ-010 SHALL have port dropped, output, 1 bit: one-cycle pulse when a press times out without ack.
REQ-011 SHALL have port press_count, output, 8 bits: count of acknowledged presses.

Function
REQ-012 SHALL pass btn through a 2-flop synchronizer per bit (reset 0); all logic below uses the synchronized value s_btn.
REQ-013 SHALL implement states IDLE, DEBOUNCE, PRESSED and WAIT_RELEASE.
REQ-014 IDLE: if s_btn is one-hot, SHALL capture it as the candidate, clear the counter and go to DEBOUNCE; a zero or multi-bit s_btn SHALL stay in IDLE.
REQ-015 DEBOUNCE: while s_btn equals the candidate, SHALL increment the counter.
REQ-016 DEBOUNCE: when the counter equals DEBOUNCE_CYCLES-1 and s_btn still matches, SHALL go to PRESSED, load color with the candidate's code, set valid=1 and clear the hold counter.
REQ-017 DEBOUNCE: any s_btn differing from the candidate (release, other button, second button) SHALL return to IDLE with color=NULL and no valid.
REQ-018 Latency: with btn held stable one-hot from before edge 1, valid SHALL rise at edge DEBOUNCE_CYCLES+3.
REQ-019 PRESSED: valid and color SHALL hold steady, independent of btn, until exit.
REQ-020 PRESSED: ack=1 SHALL clear valid, set color=NULL, increment press_count (wraps 255->0) and go to WAIT_RELEASE.
REQ-021 PRESSED: when the hold counter reaches HOLD_CYCLES-1 without ack, SHALL clear valid, set color=NULL, pulse dropped for one cycle, leave press_count unchanged and go to WAIT_RELEASE.
REQ-022 PRESSED: if ack and timeout occur in the same cycle, ack SHALL win (count increments, no dropped).
REQ-023 ack while valid=0 SHALL be ignored.
REQ-024 WAIT_RELEASE: SHALL require s_btn==0 for DEBOUNCE_CYCLES consecutive cycles, then go to IDLE; any nonzero s_btn SHALL restart the count. A held button therefore never produces a second press.
REQ-025 color SHALL equal NULL in every state except PRESSED.
REQ-026 Unreachable state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-027 reset=1 SHALL immediately, regardless of clk, force: state=IDLE, color=NULL, valid=0, dropped=0, press_count=0, all counters 0, synchronizer flops 0.
REQ-028 Reset asserted mid-DEBOUNCE or mid-PRESSED SHALL discard the pending press; after release, operation restarts from IDLE with synchronizer latency.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
REQ-029 Scenario: hold btn=4'b0100, ack at the first cycle valid is high -> valid high at edge 7 with color=2, valid low the next cycle, press_count=1.
REQ-030 Scenario: btn=4'b0001 glitched high for 2 cycles -> valid never asserts, color stays 4.
REQ-031 Scenario: btn=4'b1000 held, no ack -> valid high for 10 cycles, then one dropped pulse, press_count unchanged; keep holding 100 cycles -> no new valid.
REQ-032 Scenario: btn=4'b0011 held -> stays IDLE, valid=0, color=4.
REQ-033 Scenario: 256 acknowledged presses -> press_count reads 0; ack coincident with the timeout cycle -> counted, dropped=0.
REQ-034 Scenario: reset pulsed asynchronously between clk edges while valid=1 -> outputs reach reset values before the next edge; color=4, press_count=0.
